// File: rtl/bcd_serial_add_ctrl.sv
// Multi-digit packed-BCD adder that reuses one single-digit BCD stage, LSD first.
// Optional BCD_SUBTRACT_EN adds a sub port for ten's-complement subtraction.
module bcd_serial_add_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  cin,
`ifdef BCD_SUBTRACT_EN
  input  logic                  sub,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  invalid
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t              state, state_n;
  logic [4*DIGITS-1:0] a_r, b_r;
  logic [4*DIGITS-1:0] b_load;
  logic                c_load;
  logic [IW-1:0]       idx;
  logic [IW+1:0]       base;
  logic                carry, carry_n;
  logic [3:0]          a_dig, b_dig, dig;
  logic [4:0]          t;
  logic                bad;
  logic                load, step;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_n = state;
    busy    = 1'b0;
    done    = 1'b0;
    load    = 1'b0;
    step    = 1'b0;
    case (state)
      IDLE: if (start) begin
        load    = 1'b1;
        state_n = ADD;
      end
      ADD: begin
        busy = 1'b1;
        step = 1'b1;
        if (idx == LAST) state_n = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Operand conditioning at load time; subtraction folds into the same adder.
  always_comb begin
    b_load = b;
    c_load = cin;
`ifdef BCD_SUBTRACT_EN
    if (sub) begin
      for (int i = 0; i < DIGITS; i++)
        b_load[4*i +: 4] = 4'd9 - b[4*i +: 4];
      c_load = 1'b1;
    end
`endif
  end

  // Single-digit BCD stage: binary add, then +6 when the digit overflows decimal.
  always_comb begin
    base  = {idx, 2'b00};
    a_dig = a_r[base +: 4];
    b_dig = b_r[base +: 4];
    t     = {1'b0, a_dig} + {1'b0, b_dig} + {4'b0000, carry};
    bad   = (a_dig > 4'd9) || (b_dig > 4'd9);
    if (t > 5'd9) begin
      dig     = t[3:0] + 4'd6;
      carry_n = 1'b1;
    end else begin
      dig     = t[3:0];
      carry_n = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r     <= '0;
      b_r     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      invalid <= 1'b0;
      carry   <= 1'b0;
      idx     <= '0;
    end else if (load) begin
      a_r     <= a;
      b_r     <= b_load;
      carry   <= c_load;
      sum     <= '0;
      cout    <= 1'b0;
      invalid <= 1'b0;
      idx     <= '0;
    end else if (step) begin
      sum[base +: 4] <= dig;
      carry          <= carry_n;
      invalid        <= invalid | bad;
      if (idx == LAST) cout <= carry_n;
      else             idx  <= idx + IW'(1);
    end
  end

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Directed bench for bcd_serial_add_ctrl: vector table plus hand sequences for
// ignored starts, mid-operation reset and sticky invalid.
module tb_bcd_serial_add_ctrl;

  localparam int DIGITS = 4;

  logic        clk = 1'b0;
  logic        rst, start, cin;
  logic [15:0] a, b;
`ifdef BCD_SUBTRACT_EN
  logic        sub;
`endif
  logic        busy, done, cout, invalid;
  logic [15:0] sum;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bcd_serial_add_ctrl #(.DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
`ifdef BCD_SUBTRACT_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .sum(sum), .cout(cout), .invalid(invalid)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] sum;
    logic        cout;
    logic        invalid;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Pulses start for one edge, waits (bounded) for done, captures the results
  // and confirms done/busy drop one cycle later.
  task automatic run_op(input logic [15:0] ia, input logic [15:0] ib, input logic ic,
                        input logic is, output logic [15:0] s, output logic co,
                        output logic inv, output int lat);
    @(negedge clk);
    a = ia; b = ib; cin = ic; start = 1'b1;
`ifdef BCD_SUBTRACT_EN
    sub = is;
`endif
    @(negedge clk);
    start = 1'b0;
    a = 16'hFFFF; b = 16'hFFFF; cin = ~ic;
`ifdef BCD_SUBTRACT_EN
    sub = ~is;
`endif
    check("busy_after_start", {31'b0, busy}, 1);
    lat = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    s = sum; co = cout; inv = invalid;
    @(negedge clk);
    check("done_one_cycle", {31'b0, done}, 0);
    check("busy_drop", {31'b0, busy}, 0);
  endtask

  initial begin
    logic [15:0] s;
    logic        co, inv;
    int          lat;
    logic        seen;

    vecs.push_back('{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0});
    vecs.push_back('{16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0});
    vecs.push_back('{16'h9999, 16'h9999, 1'b1, 1'b0, 16'h9999, 1'b1, 1'b0});
    vecs.push_back('{16'h12A4, 16'h0000, 1'b0, 1'b0, 16'h1304, 1'b0, 1'b1});
    vecs.push_back('{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0});
    vecs.push_back('{16'h0909, 16'h0191, 1'b0, 1'b0, 16'h1100, 1'b0, 1'b0});
    vecs.push_back('{16'h4567, 16'h5433, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0});
`ifdef BCD_SUBTRACT_EN
    vecs.push_back('{16'h5000, 16'h1234, 1'b0, 1'b1, 16'h3766, 1'b1, 1'b0});
    vecs.push_back('{16'h1234, 16'h5000, 1'b1, 1'b1, 16'h6234, 1'b0, 1'b0});
    vecs.push_back('{16'h0042, 16'h0017, 1'b1, 1'b0, 16'h0060, 1'b0, 1'b0});
`endif

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef BCD_SUBTRACT_EN
    sub = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("reset_busy", {31'b0, busy}, 0);
    check("reset_done", {31'b0, done}, 0);
    check("reset_sum", {16'b0, sum}, 0);
    check("reset_cout", {31'b0, cout}, 0);
    check("reset_invalid", {31'b0, invalid}, 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, s, co, inv, lat);
      check($sformatf("latency[%0d]", i), lat, DIGITS);
      check($sformatf("sum[%0d]", i), {16'b0, s}, {16'b0, vecs[i].sum});
      check($sformatf("cout[%0d]", i), {31'b0, co}, {31'b0, vecs[i].cout});
      check($sformatf("invalid[%0d]", i), {31'b0, inv}, {31'b0, vecs[i].invalid});
      check($sformatf("hold_sum[%0d]", i), {16'b0, sum}, {16'b0, vecs[i].sum});
    end

    // Starts during ADD and during DONE are ignored.
    @(negedge clk);
    a = 16'h0005; b = 16'h0003; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 16'h1111; b = 16'h1111;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("ign_done_seen", {31'b0, done}, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ign_busy_after_done", {31'b0, busy}, 0);
    check("ign_sum", {16'b0, sum}, 16'h0008);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen = seen | done | busy;
    end
    check("ign_no_second_op", {31'b0, seen}, 0);

    // Reset in mid-ADD after digit 1 is written, then held with start high.
    @(negedge clk);
    a = 16'h5678; b = 16'h1111; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("partial_sum", {16'b0, sum}, 16'h0089);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_sum", {16'b0, sum}, 0);
    check("rst_cout", {31'b0, cout}, 0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("rst_start_dropped", {31'b0, busy}, 0);
    run_op(16'h0009, 16'h0008, 1'b0, 1'b0, s, co, inv, lat);
    check("post_rst_lat", lat, DIGITS);
    check("post_rst_sum", {16'b0, s}, 16'h0017);
    check("post_rst_cout", {31'b0, co}, 0);

    // Sticky invalid, cleared by the next accepted start.
    run_op(16'h12A4, 16'h0000, 1'b0, 1'b0, s, co, inv, lat);
    check("inv_set", {31'b0, inv}, 1);
    check("inv_hold", {31'b0, invalid}, 1);
    run_op(16'h0001, 16'h0002, 1'b0, 1'b0, s, co, inv, lat);
    check("inv_clear", {31'b0, inv}, 0);
    check("inv_clear_sum", {16'b0, s}, 16'h0003);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
